// File: rtl/diffeq_pkg.sv
// diffeq_pkg: shared types and constants
// for the differentiator operand sequencer.
package diffeq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_X,
        LD_DX,
        LD_A,
        LD_U,
        WAIT,
        OUT
    } state_t;

    localparam int X_MSB  = 15;
    localparam int DX_MSB = 11;
    localparam int A_MSB  = 7;
    localparam int U_MSB  = 3;

    localparam logic [15:0] TIMEOUT_SENTINEL = 16'hFFFF;

endpackage

// File: rtl/diffeq_operand_sequencer.sv
// diffeq_operand_sequencer: replays a packed
// operand command into the differentiator core.
module diffeq_operand_sequencer
    import diffeq_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic [3:0]  core_in,
    output logic        s1,
    output logic        s2,
    output logic        s3,
    output logic        s4,
    output logic        core_ready,
    input  logic        core_valid,
    input  logic [15:0] core_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int CW = (TW > HW) ? TW : HW;

    localparam logic [CW-1:0] PH_LOAD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [15:0]   op, op_d;
    logic          armed, armed_d;
    logic [15:0]   data_d;
    logic          err_d;
    logic [3:0]    nib_d;
    logic [3:0]    stb_d;

    // Next state; the counter times load phases, then the WAIT timeout.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_d    = op;
        armed_d = armed;
        data_d  = res_data;
        err_d   = res_err;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_data;
                    cnt_d   = PH_LOAD;
                    state_d = LD_X;
                end
            end
            LD_X, LD_DX, LD_A: begin
                if (cnt == '0) begin
                    cnt_d = PH_LOAD;
                    unique case (state)
                        LD_X:    state_d = LD_DX;
                        LD_DX:   state_d = LD_A;
                        default: state_d = LD_U;
                    endcase
                end else begin
                    cnt_d = cnt - ONE;
                end
            end
            LD_U: begin
                if (cnt == '0) begin
                    cnt_d   = TO_LOAD;
                    armed_d = 1'b0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt - ONE;
                end
            end
            WAIT: begin
                armed_d = armed | ~core_valid;
                if (armed && core_valid) begin
                    data_d  = core_out;
                    err_d   = 1'b0;
                    state_d = OUT;
                end else if (cnt == '0) begin
                    data_d  = TIMEOUT_SENTINEL;
                    err_d   = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt - ONE;
                end
            end
            OUT: begin
                if (res_valid && res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Nibble and strobe for the upcoming cycle; gap cycle drops the strobe.
    always_comb begin
        nib_d = 4'h0;
        stb_d = 4'b0000;
        unique case (state_d)
            LD_X: begin
                nib_d    = op_d[X_MSB -: 4];
                stb_d[0] = (cnt_d != '0);
            end
            LD_DX: begin
                nib_d    = op_d[DX_MSB -: 4];
                stb_d[1] = (cnt_d != '0);
            end
            LD_A: begin
                nib_d    = op_d[A_MSB -: 4];
                stb_d[2] = (cnt_d != '0);
            end
            LD_U: begin
                nib_d    = op_d[U_MSB -: 4];
                stb_d[3] = (cnt_d != '0);
            end
            default: ;
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op         <= '0;
            armed      <= 1'b0;
            cmd_ready  <= 1'b0;
            core_in    <= 4'h0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            s4         <= 1'b0;
            core_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= 16'h0;
            res_err    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            op         <= op_d;
            armed      <= armed_d;
            cmd_ready  <= (state_d == IDLE);
            core_in    <= nib_d;
            s1         <= stb_d[0];
            s2         <= stb_d[1];
            s3         <= stb_d[2];
            s4         <= stb_d[3];
            core_ready <= (state_d == WAIT);
            res_valid  <= (state_d == OUT);
            res_data   <= data_d;
            res_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_diffeq_operand_sequencer.sv
// tb_diffeq_operand_sequencer: table-driven and
// randomized checks against a transaction-level model.
module tb_diffeq_operand_sequencer;

    localparam int H = 2;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic [3:0]  core_in;
    logic        s1, s2, s3, s4;
    logic        core_ready;
    logic        core_valid;
    logic [15:0] core_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;

    int total = 0;
    int pass  = 0;

    diffeq_operand_sequencer #(
        .HOLD_CYCLES(H),
        .TIMEOUT    (T)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .core_in   (core_in),
        .s1        (s1),
        .s2        (s2),
        .s3        (s3),
        .s4        (s4),
        .core_ready(core_ready),
        .core_valid(core_valid),
        .core_out  (core_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] v;
        logic [15:0] cout;
        int          hold;
        bit          pend;
        logic [15:0] nxt;
        int          ek;
        bit          eerr;
        logic [15:0] edata;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [27:0] all_out();
        return {cmd_ready, core_in, s1, s2, s3, s4,
                core_ready, res_valid, res_data, res_err};
    endfunction

    // Core response rule: v[k] is core_valid at the k-th WAIT
    // sample. A sample counts only after some earlier low sample;
    // without one by sample T-1 the run times out.
    task automatic model(input logic [15:0] v,
                         input logic [15:0] cout,
                         output int k,
                         output bit err,
                         output logic [15:0] data);
        bit seen_low = 0;
        k    = T - 1;
        err  = 1;
        data = 16'hFFFF;
        for (int i = 0; i < T; i++) begin
            if (seen_low && v[i] && err) begin
                k    = i;
                err  = 0;
                data = cout;
            end
            if (!v[i]) seen_low = 1;
        end
    endtask

    task automatic xact(input logic [15:0] cmd,
                        input logic [15:0] v,
                        input logic [15:0] cout,
                        input int hold,
                        input bit pend,
                        input logic [15:0] nxt,
                        input int ek,
                        input bit eerr,
                        input logic [15:0] edata);
        logic [15:0] sh;
        logic [3:0]  sv;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid  = 1;
        cmd_data   = cmd;
        core_valid = v[0];
        core_out   = cout;
        res_ready  = 1;
        tick();
        cmd_valid = 0;
        cmd_data  = 16'h0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c <= H; c++) begin
                sh = cmd >> (12 - 4 * p);
                sv = (c < H) ? (4'b1000 >> p) : 4'b0000;
                chk("load_strobes", {s1, s2, s3, s4}, sv);
                chk("load_nibble", core_in, sh[3:0]);
                chk("load_busy", {cmd_ready, core_ready, res_valid}, 0);
                tick();
            end
        end
        res_ready = 0;
        for (int k = 0; k <= ek; k++) begin
            chk("wait_core_ready", core_ready, 1);
            chk("wait_quiet", {res_valid, cmd_ready, core_in, s1, s2, s3, s4}, 0);
            core_valid = v[k];
            tick();
        end
        chk("res_valid_rise", res_valid, 1);
        chk("core_ready_fall", core_ready, 0);
        chk("res_data", res_data, edata);
        chk("res_err", res_err, eerr);
        core_valid = 0;
        for (int h = 0; h < hold; h++) begin
            if (pend) begin
                cmd_valid = 1;
                cmd_data  = nxt;
            end
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, edata);
            chk("hold_err", res_err, eerr);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        if (pend) begin
            cmd_valid = 1;
            cmd_data  = nxt;
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        chk("res_valid_fall", res_valid, 0);
        chk("cmd_ready_rise", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] cur, nxt, v, cout, ed;
        bit          pend, ee;
        int          ek;

        tbl[0] = '{16'h3179, 16'h0008, 16'd42,   1, 0, 16'h0,    3, 0, 16'd42};
        tbl[1] = '{16'h5A0F, 16'h0002, 16'hBEEF, 5, 1, 16'hC0DE, 1, 0, 16'hBEEF};
        tbl[2] = '{16'hC0DE, 16'h0005, 16'h0123, 0, 1, 16'h0F0F, 2, 0, 16'h0123};
        tbl[3] = '{16'h0F0F, 16'h0000, 16'h7777, 2, 0, 16'h0,    7, 1, 16'hFFFF};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 16'h1111, 0, 0, 16'h0,    7, 1, 16'hFFFF};
        tbl[5] = '{16'h8421, 16'h0080, 16'h2222, 1, 0, 16'h0,    7, 0, 16'h2222};
        tbl[6] = '{16'h0000, 16'h000B, 16'h9999, 0, 0, 16'h0,    3, 0, 16'h9999};
        tbl[7] = '{16'hFEDC, 16'h0001, 16'h4444, 0, 0, 16'h0,    7, 1, 16'hFFFF};

        rst        = 0;
        cmd_valid  = 0;
        cmd_data   = 0;
        core_valid = 0;
        core_out   = 0;
        res_ready  = 0;
        tick();
        tick();
        chk("reset_outputs", all_out(), 0);
        rst = 1;
        tick();
        chk("post_reset", all_out(), 28'h800_0000);

        for (int i = 0; i < 8; i++) begin
            xact(tbl[i].cmd, tbl[i].v, tbl[i].cout, tbl[i].hold,
                 tbl[i].pend, tbl[i].nxt, tbl[i].ek, tbl[i].eerr,
                 tbl[i].edata);
        end

        chk("midload_idle", cmd_ready, 1);
        cmd_valid = 1;
        cmd_data  = 16'h1234;
        tick();
        cmd_valid = 0;
        repeat (6) tick();
        chk("midload_s3", {s1, s2, s3, s4}, 4'b0010);
        chk("midload_nib", core_in, 4'h3);
        rst = 0;
        tick();
        chk("midload_reset", all_out(), 0);
        rst = 1;
        tick();
        chk("midload_release", all_out(), 28'h800_0000);
        xact(16'hA5C3, 16'h0002, 16'h5555, 0, 0, 16'h0, 1, 0, 16'h5555);

        cur = 16'($urandom);
        for (int i = 0; i < 24; i++) begin
            nxt  = 16'($urandom);
            pend = 1'($urandom_range(0, 1));
            v    = 16'($urandom);
            if (i % 6 == 0) v = 16'h0;
            if (i % 6 == 3) v = 16'hFFFF;
            cout = 16'($urandom);
            model(v, cout, ek, ee, ed);
            xact(cur, v, cout, $urandom_range(0, 3), pend, nxt, ek, ee, ed);
            cur = pend ? nxt : 16'($urandom);
        end
        cmd_valid = 0;
        tick();

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
